stm32_iq_scheduler: RTL

//  Buffers DDC I/Q samples in a FIFO; serves them to the STM32 over the 4-bit nibble bus on command.

---
 rtl/stm32_iq_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/stm32_iq_scheduler.sv
// stm32_iq_scheduler: buffers DDC {Q,I} samples and serves them to the STM32 over a 4-bit nibble bus.
// Latency: opcode taken on the DATA_SYNC cycle; first IQ nibble or status nibble on DATA_OUT the next cycle.
// Backpressure: none toward the DDC; a sample arriving on a full FIFO is dropped and flagged in overflow.
// Build option: define STM32_IQ_PARITY_EN to append an XOR check nibble as the 9th nibble of each IQ burst.
module stm32_iq_scheduler #(
    parameter int FIFO_AW = 4,
    parameter int IQ_W    = 16
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               iq_valid,
    input  logic [IQ_W-1:0]    I,
    input  logic [IQ_W-1:0]    Q,
    input  logic               ADC_OTR,
    input  logic               DATA_SYNC,
    input  logic [3:0]         DATA_IN,
    output logic [3:0]         DATA_OUT,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               busy
);

    localparam logic [3:0] OP_SEND_IQ     = 4'd4;
    localparam logic [3:0] OP_SEND_STATUS = 4'd2;
    localparam logic [3:0] OP_FLUSH       = 4'd5;

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam int                 EW         = 2 * IQ_W;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    // S_IQ covers the eight data nibbles (nib_idx 0..7); S_PAR is the optional check nibble.
    typedef enum logic [1:0] {
        S_IDLE,
        S_IQ,
        S_PAR,
        S_STAT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       nib_idx;
    logic [2:0]       nib_idx_next;
    logic [2:0]       nib_idx_inc;
    logic [3:0]       dout_next;

    // Sample being shifted out; loaded from the FIFO head on the SEND_IQ sync cycle.
    logic [EW-1:0]    hold;

    logic [EW-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   level;
    logic [EW-1:0]      head;

    logic             underrun;
    logic             otr_l;

    logic             cmd_iq;
    logic             cmd_status;
    logic             cmd_flush;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;

    assign cmd_iq      = DATA_SYNC && (DATA_IN == OP_SEND_IQ);
    assign cmd_status  = DATA_SYNC && (DATA_IN == OP_SEND_STATUS);
    assign cmd_flush   = DATA_SYNC && (DATA_IN == OP_FLUSH);

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == FULL_LEVEL);
    assign head        = mem[rd_ptr];

    // A pop frees the head slot in the same edge, so a push is still accepted when full.
    assign do_pop      = cmd_iq && !fifo_empty;
    assign do_push     = iq_valid && !cmd_flush && (!fifo_full || do_pop);
    assign ovf_set     = iq_valid && !cmd_flush && fifo_full && !do_pop;

    assign nib_idx_inc = nib_idx + 3'd1;

    assign fifo_level  = level;
    assign busy        = (state == S_IQ) || (state == S_PAR);

`ifdef STM32_IQ_PARITY_EN
    logic [3:0] iq_parity;

    // XOR of all eight nibbles of the held sample.
    always_comb begin
        iq_parity = 4'h0;
        for (int k = 0; k < 8; k++) begin
            iq_parity = iq_parity ^ hold[k*4 +: 4];
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            nib_idx <= 3'd0;
        end else begin
            state   <= state_next;
            nib_idx <= nib_idx_next;
        end
    end

    // Next state and next DATA_OUT nibble; a DATA_SYNC command preempts any burst in flight.
    always_comb begin
        state_next   = state;
        nib_idx_next = nib_idx;
        dout_next    = DATA_OUT;
        if (DATA_SYNC) begin
            nib_idx_next = 3'd0;
            case (DATA_IN)
                OP_SEND_IQ: begin
                    state_next = S_IQ;
                    dout_next  = fifo_empty ? 4'h0 : head[EW-1 -: 4];
                end
                OP_SEND_STATUS: begin
                    state_next = S_STAT;
                    dout_next  = {overflow, underrun, fifo_full, otr_l};
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end else begin
            case (state)
                S_IQ: begin
                    if (nib_idx == 3'd7) begin
`ifdef STM32_IQ_PARITY_EN
                        state_next = S_PAR;
                        dout_next  = iq_parity;
`else
                        state_next = S_IDLE;
`endif
                    end else begin
                        nib_idx_next = nib_idx_inc;
                        // Nibble n sits at bits [31-4n -: 4]; for 3-bit n, 7-n == ~n.
                        dout_next    = hold[{~nib_idx_inc, 2'b00} +: 4];
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers and level.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= {Q, I};
        end
    end

    // Output nibble, held sample, sticky flags (set beats clear) and FIFO bookkeeping.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            DATA_OUT <= 4'h0;
            hold     <= '0;
            overflow <= 1'b0;
            underrun <= 1'b0;
            otr_l    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
        end else begin
            DATA_OUT <= dout_next;
            if (cmd_iq) begin
                hold <= fifo_empty ? '0 : head;
            end
            overflow <= ovf_set | (overflow & ~cmd_status);
            underrun <= (cmd_iq & fifo_empty) | (underrun & ~cmd_status);
            otr_l    <= ADC_OTR | (otr_l & ~cmd_status);
            if (cmd_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                case ({do_push, do_pop})
                    2'b10:   level <= level + LVL_ONE;
                    2'b01:   level <= level - LVL_ONE;
                    default: level <= level;
                endcase
            end
        end
    end

endmodule
